// File: rtl/tbs_uart_pkg.sv
// Shared types and constants for the ATBS UART command receiver.
// Used by the byte deserialiser and the frame parser.
package tbs_uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} rx_state_t;
  typedef enum logic [1:0] {P_HDR, P_ADDR, P_DATA, P_CHK} parser_state_t;

  localparam logic [7:0] CMD_HDR    = 8'hA5;
  localparam int         CFG_ADDR_W = 4;

  // Frame check byte: header, address and data XORed together.
  function automatic logic [7:0] frame_chk(input logic [7:0] addr, input logic [7:0] data);
    return CMD_HDR ^ addr ^ data;
  endfunction

endpackage

// File: rtl/tbs_uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop input synchroniser plus mid-bit sampling FSM.
// Emits one-cycle valid / frame_err pulses; the byte output holds the last good byte.
module tbs_uart_rx_byte
  import tbs_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clock_i,
  input  logic       reset_n_i,
  input  logic       uart_rx_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       frame_err_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_rx_prev;
  rx_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_byte;
  logic             r_valid;
  logic             r_frame_err;
  logic             w_rx;

  assign w_rx        = r_sync2;
  assign byte_o      = r_byte;
  assign valid_o     = r_valid;
  assign frame_err_o = r_frame_err;

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      // Synchroniser loads idle-high so reset release cannot look like a start bit.
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_byte      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync1     <= uart_rx_i;
      r_sync2     <= r_sync1;
      r_rx_prev   <= w_rx;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_rx_prev && !w_rx) begin
            r_state <= START;
            r_cnt   <= '0;
          end
        end
        START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= w_rx ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt     <= '0;
            r_shift   <= {w_rx, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) begin
              r_state <= STOP;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt <= '0;
            if (w_rx) begin
              r_byte  <= r_shift;
              r_valid <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= WAIT_HI;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_HI: begin
          if (w_rx) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tbs_uart_cmd_rx.sv
// UART command receiver: decodes {A5, ADDR, DATA, CHK} frames into config writes,
// with an inter-byte timeout and a saturating rejected-frame counter.
module tbs_uart_cmd_rx
  import tbs_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  uart_rx_i,
  output logic                  rx_byte_valid_o,
  output logic [7:0]            rx_byte_o,
  output logic                  cfg_wr_o,
  output logic [CFG_ADDR_W-1:0] cfg_addr_o,
  output logic [7:0]            cfg_data_o,
  output logic [7:0]            err_cnt_o
);

  localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W      = $clog2(TO_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

  logic [7:0]            w_byte;
  logic                  w_valid;
  logic                  w_frame_err;
  logic                  w_in_frame;
  logic                  w_addr_bad;
  logic                  w_chk_ok;
  logic                  w_to_hit;
  logic                  w_err;

  parser_state_t         r_pstate;
  logic [CFG_ADDR_W-1:0] r_addr;
  logic [7:0]            r_data;
  logic [TO_W-1:0]       r_to_cnt;
  logic                  r_cfg_wr;
  logic [CFG_ADDR_W-1:0] r_cfg_addr;
  logic [7:0]            r_cfg_data;
  logic [7:0]            r_err_cnt;

  tbs_uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx_byte (
    .clock_i     (clock_i),
    .reset_n_i   (reset_n_i),
    .uart_rx_i   (uart_rx_i),
    .byte_o      (w_byte),
    .valid_o     (w_valid),
    .frame_err_o (w_frame_err)
  );

  assign w_in_frame = (r_pstate != P_HDR);
  assign w_addr_bad = (w_byte[7:CFG_ADDR_W] != '0);
  assign w_chk_ok   = (w_byte == frame_chk(8'(r_addr), r_data));
  assign w_to_hit   = (r_to_cnt == TO_LAST);

  // A valid byte in the same cycle as a framing error or timeout takes priority.
  always_comb begin
    w_err = 1'b0;
    if (w_valid) begin
      w_err = ((r_pstate == P_ADDR) && w_addr_bad) || ((r_pstate == P_CHK) && !w_chk_ok);
    end else begin
      w_err = w_in_frame && (w_frame_err || w_to_hit);
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      r_pstate   <= P_HDR;
      r_addr     <= '0;
      r_data     <= '0;
      r_to_cnt   <= '0;
      r_cfg_wr   <= 1'b0;
      r_cfg_addr <= '0;
      r_cfg_data <= '0;
    end else begin
      r_cfg_wr <= 1'b0;
      if (w_valid) begin
        r_to_cnt <= '0;
        case (r_pstate)
          P_HDR: begin
            if (w_byte == CMD_HDR) begin
              r_pstate <= P_ADDR;
            end
          end
          P_ADDR: begin
            r_addr   <= w_byte[CFG_ADDR_W-1:0];
            r_pstate <= w_addr_bad ? P_HDR : P_DATA;
          end
          P_DATA: begin
            r_data   <= w_byte;
            r_pstate <= P_CHK;
          end
          P_CHK: begin
            if (w_chk_ok) begin
              r_cfg_wr   <= 1'b1;
              r_cfg_addr <= r_addr;
              r_cfg_data <= r_data;
            end
            r_pstate <= P_HDR;
          end
          default: r_pstate <= P_HDR;
        endcase
      end else if (w_err) begin
        r_pstate <= P_HDR;
        r_to_cnt <= '0;
      end else if (w_in_frame) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      r_err_cnt <= '0;
    end else if (w_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign rx_byte_valid_o = w_valid;
  assign rx_byte_o       = w_byte;
  assign cfg_wr_o        = r_cfg_wr;
  assign cfg_addr_o      = r_cfg_addr;
  assign cfg_data_o      = r_cfg_data;
  assign err_cnt_o       = r_err_cnt;

endmodule

// File: tb/tb_tbs_uart_cmd_rx.sv
// Self-checking bench for tbs_uart_cmd_rx: table of frames, hand-built corner cases,
// and random frames whose outcome is derived from the frame rules.
module tb_tbs_uart_cmd_rx;

  localparam int CPB = 16;
  localparam int TOB = 20;

  logic       clock_i   = 1'b0;
  logic       reset_n_i = 1'b0;
  logic       uart_rx_i = 1'b1;
  logic       rx_byte_valid_o;
  logic [7:0] rx_byte_o;
  logic       cfg_wr_o;
  logic [3:0] cfg_addr_o;
  logic [7:0] cfg_data_o;
  logic [7:0] err_cnt_o;

  tbs_uart_cmd_rx #(
    .CLKS_PER_BIT (CPB),
    .TIMEOUT_BITS (TOB)
  ) dut (
    .clock_i         (clock_i),
    .reset_n_i       (reset_n_i),
    .uart_rx_i       (uart_rx_i),
    .rx_byte_valid_o (rx_byte_valid_o),
    .rx_byte_o       (rx_byte_o),
    .cfg_wr_o        (cfg_wr_o),
    .cfg_addr_o      (cfg_addr_o),
    .cfg_data_o      (cfg_data_o),
    .err_cnt_o       (err_cnt_o)
  );

  always #5 clock_i = ~clock_i;

  int n_vec  = 0;
  int n_miss = 0;

  // Observed pulse counts
  int   wr_cnt  = 0;
  int   vld_cnt = 0;
  int   dbl_wr  = 0;
  logic wr_prev = 1'b0;

  // Expected state
  int         exp_wr   = 0;
  int         exp_vld  = 0;
  int         exp_err  = 0;
  logic [3:0] exp_addr = '0;
  logic [7:0] exp_data = '0;
  logic [7:0] exp_byte = '0;

  always @(negedge clock_i) begin
    if (reset_n_i) begin
      if (cfg_wr_o) begin
        wr_cnt++;
        if (wr_prev) dbl_wr++;
      end
      if (rx_byte_valid_o) vld_cnt++;
    end
    wr_prev = cfg_wr_o;
  end

  typedef struct {
    logic [7:0] b [4];
    int         bad_stop;
    logic       exp_wr;
    logic [3:0] exp_a;
    logic [7:0] exp_d;
    int         err_inc;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " wr_count"}, wr_cnt, exp_wr);
    check({tag, " cfg_addr"}, int'(cfg_addr_o), int'(exp_addr));
    check({tag, " cfg_data"}, int'(cfg_data_o), int'(exp_data));
    check({tag, " err_cnt"}, int'(err_cnt_o), exp_err);
    check({tag, " valid_count"}, vld_cnt, exp_vld);
    check({tag, " rx_byte"}, int'(rx_byte_o), int'(exp_byte));
  endtask

  task automatic bit_time(input logic v);
    uart_rx_i = v;
    repeat (CPB) @(negedge clock_i);
  endtask

  task automatic idle_bits(input int n);
    uart_rx_i = 1'b1;
    repeat (n * CPB) @(negedge clock_i);
  endtask

  // A byte with a bad stop bit is followed by two idle bits so the line recovers.
  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop_ok);
    if (stop_ok) begin
      exp_vld++;
      exp_byte = b;
    end else begin
      idle_bits(2);
    end
  endtask

  task automatic bump_err();
    exp_err = (exp_err < 255) ? exp_err + 1 : 255;
  endtask

  task automatic expect_write(input logic [3:0] a, input logic [7:0] d);
    exp_wr++;
    exp_addr = a;
    exp_data = d;
  endtask

  task automatic model_reset();
    exp_wr = 0; exp_vld = 0; exp_err = 0;
    exp_addr = '0; exp_data = '0; exp_byte = '0;
    wr_cnt = 0; vld_cnt = 0;
  endtask

  initial begin
    logic [7:0] a8, d8, c8;
    int kind;

    // Frames applied back to back; expectations are deltas on the running model.
    vecs[0] = '{'{8'hA5, 8'h03, 8'h5C, 8'hFA}, -1, 1'b1, 4'h3, 8'h5C, 0};
    vecs[1] = '{'{8'hA5, 8'h03, 8'h5C, 8'h00}, -1, 1'b0, 4'h0, 8'h00, 1};
    vecs[2] = '{'{8'hA5, 8'h03, 8'h5C, 8'hFA}, -1, 1'b1, 4'h3, 8'h5C, 0};
    vecs[3] = '{'{8'hA5, 8'h03, 8'h5C, 8'hFA},  2, 1'b0, 4'h0, 8'h00, 1};
    vecs[4] = '{'{8'hA5, 8'h0A, 8'hFF, 8'h50}, -1, 1'b1, 4'hA, 8'hFF, 0};
    vecs[5] = '{'{8'hA5, 8'h13, 8'h5C, 8'hEA}, -1, 1'b0, 4'h0, 8'h00, 1};
    vecs[6] = '{'{8'hA5, 8'h03, 8'h5C, 8'hFA},  0, 1'b0, 4'h0, 8'h00, 0};
    vecs[7] = '{'{8'hA5, 8'h00, 8'h00, 8'hA5}, -1, 1'b1, 4'h0, 8'h00, 0};
    vecs[8] = '{'{8'hA5, 8'h03, 8'h5C, 8'hFA}, -1, 1'b1, 4'h3, 8'h5C, 0};

    repeat (4) @(negedge clock_i);
    reset_n_i = 1'b1;
    repeat (2) @(negedge clock_i);
    check("reset rx_byte_valid", int'(rx_byte_valid_o), 0);
    check_all("reset");

    foreach (vecs[v]) begin
      for (int k = 0; k < 4; k++) send_byte(vecs[v].b[k], (k != vecs[v].bad_stop));
      if (vecs[v].exp_wr) expect_write(vecs[v].exp_a, vecs[v].exp_d);
      for (int e = 0; e < vecs[v].err_inc; e++) bump_err();
      idle_bits(1);
      check_all($sformatf("vec%0d", v));
    end

    // Junk bytes immediately before a frame, no idle anywhere
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h0F, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hAB, 1'b1);
    expect_write(4'hF, 8'h01);
    idle_bits(1);
    check_all("junk_then_frame");

    // Short low glitch on an idle line
    uart_rx_i = 1'b0;
    repeat (4) @(negedge clock_i);
    idle_bits(2);
    check("glitch valid_count", vld_cnt, exp_vld);
    check("glitch err_cnt", int'(err_cnt_o), exp_err);

    // Random frames; outcome follows from how each frame was built
    for (int r = 0; r < 8; r++) begin
      kind = int'($urandom_range(0, 3));
      a8 = {4'h0, 4'($urandom_range(0, 15))};
      d8 = 8'($urandom);
      case (kind)
        0: begin
          c8 = 8'hA5 ^ a8 ^ d8;
          expect_write(a8[3:0], d8);
        end
        1: begin
          c8 = (8'hA5 ^ a8 ^ d8) ^ 8'($urandom_range(1, 255));
          bump_err();
        end
        2: begin
          a8 = {4'($urandom_range(1, 15)), 4'($urandom)};
          do d8 = 8'($urandom); while (d8 == 8'hA5);
          do c8 = 8'($urandom); while (c8 == 8'hA5);
          bump_err();
        end
        default: begin
          do c8 = 8'($urandom); while (c8 == 8'hA5);
        end
      endcase
      if (kind != 3) begin
        send_byte(8'hA5, 1'b1);
        send_byte(a8, 1'b1);
        send_byte(d8, 1'b1);
      end
      send_byte(c8, 1'b1);
      idle_bits(1);
      check_all($sformatf("rand%0d kind%0d", r, kind));
    end

    // Timeout: header then silence, checked just before and after the limit
    send_byte(8'hA5, 1'b1);
    idle_bits(TOB - 1);
    check("timeout_not_yet err_cnt", int'(err_cnt_o), exp_err);
    idle_bits(2);
    bump_err();
    check("timeout err_cnt", int'(err_cnt_o), exp_err);

    // Saturation with short bad-address frames
    while (exp_err < 255) begin
      send_byte(8'hA5, 1'b1);
      send_byte(8'h10, 1'b1);
      bump_err();
    end
    idle_bits(1);
    check("sat_reach err_cnt", int'(err_cnt_o), 255);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h10, 1'b1);
    bump_err();
    idle_bits(1);
    check("sat_hold err_cnt", int'(err_cnt_o), exp_err);

    // Reset in the middle of the data bits of a byte
    uart_rx_i = 1'b0;
    repeat (3 * CPB) @(negedge clock_i);
    reset_n_i = 1'b0;
    repeat (3) @(negedge clock_i);
    uart_rx_i = 1'b1;
    repeat (2) @(negedge clock_i);
    reset_n_i = 1'b1;
    model_reset();
    @(negedge clock_i);
    check("midreset rx_byte_valid", int'(rx_byte_valid_o), 0);
    check("midreset cfg_wr", int'(cfg_wr_o), 0);
    check_all("midreset");
    idle_bits(1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h5C, 1'b1);
    send_byte(8'hFA, 1'b1);
    expect_write(4'h3, 8'h5C);
    idle_bits(1);
    check_all("after_reset_frame");

    check("no_consecutive_cfg_wr", dbl_wr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
